// File: rtl/and2_fabric_formal_top.sv
// One FPGA logic cell (routing muxes, 4-input LUT, optional output flop) fixed by parameters to implement c = a & b.
// Latency: zero cycles with REGISTERED=0 (pure combinational); one clk cycle with REGISTERED=1.
// Backpressure: none; there is no handshake or enable, and the output follows the inputs unconditionally.
`timescale 1ns/10ps
module and2_fabric_formal_top #(
    parameter logic [15:0] LUT_INIT   = 16'h0008,
    parameter logic [1:0]  SEL_IN0    = 2'd0,
    parameter logic [1:0]  SEL_IN1    = 2'd1,
    parameter logic [1:0]  SEL_IN2    = 2'd2,
    parameter logic [1:0]  SEL_IN3    = 2'd2,
    parameter logic        REGISTERED = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic c
);

    // Static routing mux: selects a user input or a tie-off constant.
    // Encoding: 0 = a, 1 = b, 2 = constant 0, 3 = constant 1.
    function automatic logic route(input logic [1:0] sel, input logic ia, input logic ib);
        logic r;
        case (sel)
            2'd0:    r = ia;
            2'd1:    r = ib;
            2'd2:    r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [3:0] w_lut_idx;
    logic       w_lut_out;
    logic       r_ff_q;

    // Input routing: build the LUT address {in3,in2,in1,in0} from the selected sources.
    always_comb begin
        w_lut_idx    = 4'd0;
        w_lut_idx[0] = route(SEL_IN0, a, b);
        w_lut_idx[1] = route(SEL_IN1, a, b);
        w_lut_idx[2] = route(SEL_IN2, a, b);
        w_lut_idx[3] = route(SEL_IN3, a, b);
    end

    // LUT: 16:1 mux over the truth table, indexed by the routed inputs.
    always_comb begin
        w_lut_out = LUT_INIT[w_lut_idx];
    end

    // Cell flip-flop: captures the LUT output each rising edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_q <= 1'b0;
        end else begin
            r_ff_q <= w_lut_out;
        end
    end

    // Output mux: REGISTERED is an elaboration constant, so in the default build
    // c is a pure function of a/b and never sees clk, rst_n or the flop state.
    assign c = REGISTERED ? r_ff_q : w_lut_out;

endmodule

// File: tb/tb_and2_fabric_formal_top.sv
`timescale 1ns/10ps
module tb_and2_fabric_formal_top;

    int checks   = 0;
    int failures = 0;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic a      = 1'b0;
    logic b      = 1'b0;
    logic rst_n_def;          // intentionally left undriven until the reset-path test
    logic rst_n_reg = 1'b0;
    logic rst_n_xor = 1'b1;
    logic c_def;
    logic c_reg;
    logic c_xor;

    // 2 ns period clock that can be parked low
    always begin
        #1;
        if (clk_en) clk = ~clk;
        else        clk = 1'b0;
    end

    and2_fabric_formal_top u_def (
        .clk   (clk),
        .rst_n (rst_n_def),
        .a     (a),
        .b     (b),
        .c     (c_def)
    );

    and2_fabric_formal_top #(.REGISTERED(1'b1)) u_reg (
        .clk   (clk),
        .rst_n (rst_n_reg),
        .a     (a),
        .b     (b),
        .c     (c_reg)
    );

    and2_fabric_formal_top #(.LUT_INIT(16'h0006)) u_xor (
        .clk   (clk),
        .rst_n (rst_n_xor),
        .a     (a),
        .b     (b),
        .c     (c_xor)
    );

    task automatic test_reset;
        a = 1'b0;
        b = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (c_def !== 1'b0) begin
            failures++;
            $display("FAIL reset_default_c: got %b expected 0", c_def);
        end
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reset_registered_c: got %b expected 0", c_reg);
        end
    endtask

    task automatic test_truth_table;
        logic [1:0] va [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       ex [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = va[i][1];
            b = va[i][0];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (c_def !== ex[i]) begin
                failures++;
                $display("FAIL truth_table a=%b b=%b: got %b expected %b", va[i][1], va[i][0], c_def, ex[i]);
            end
        end
    endtask

    task automatic test_sequence;
        logic [1:0] va [3] = '{2'b01, 2'b10, 2'b11};
        logic       ex [3] = '{1'b0, 1'b0, 1'b1};
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = va[i][1];
            b = va[i][0];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (c_def !== ex[i]) begin
                failures++;
                $display("FAIL sequence step %0d: got %b expected %b", i, c_def, ex[i]);
            end
        end
    endtask

    task automatic test_clk_stopped;
        // a/b pairs chosen so every pair and simultaneous double toggles appear
        logic [1:0] va [8] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
        logic       ex [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        for (int i = 0; i < 8; i++) begin
            a = va[i][1];
            b = va[i][0];
            #0.1;
            checks++;
            if (c_def !== ex[i]) begin
                failures++;
                $display("FAIL clk_stopped step %0d: got %b expected %b", i, c_def, ex[i]);
            end
        end
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_comb_path;
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        rst_n_def = 1'b0;
        #0.1;
        checks++;
        if (c_def !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb_path: got %b expected 1", c_def);
        end
        @(posedge clk);
        #0.1;
        checks++;
        if (c_def !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb_path_after_edge: got %b expected 1", c_def);
        end
        rst_n_def = 1'b1;
    endtask

    task automatic test_registered;
        rst_n_reg = 1'b0;
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        @(posedge clk);
        #0.1;
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reg_held_in_reset: got %b expected 0", c_reg);
        end
        @(negedge clk);
        rst_n_reg = 1'b1;
        #0.1;
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reg_before_first_edge: got %b expected 0", c_reg);
        end
        @(posedge clk);
        #0.1;
        checks++;
        if (c_reg !== 1'b1) begin
            failures++;
            $display("FAIL reg_first_capture: got %b expected 1", c_reg);
        end
        // one-cycle latency: dropping a must not show until the next edge
        @(negedge clk);
        a = 1'b0;
        #0.1;
        checks++;
        if (c_reg !== 1'b1) begin
            failures++;
            $display("FAIL reg_latency_hold: got %b expected 1", c_reg);
        end
        @(posedge clk);
        #0.1;
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reg_latency_update: got %b expected 0", c_reg);
        end
        @(negedge clk);
        a = 1'b1;
        @(posedge clk);
        #0.1;
        checks++;
        if (c_reg !== 1'b1) begin
            failures++;
            $display("FAIL reg_recapture: got %b expected 1", c_reg);
        end
        // mid-cycle asynchronous reset
        #0.4;
        rst_n_reg = 1'b0;
        #0.05;
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reg_async_reset: got %b expected 0", c_reg);
        end
        @(posedge clk);
        #0.1;
        checks++;
        if (c_reg !== 1'b0) begin
            failures++;
            $display("FAIL reg_reset_held_over_edge: got %b expected 0", c_reg);
        end
        rst_n_reg = 1'b1;
    endtask

    task automatic test_lut_xor;
        logic [1:0] va [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       ex [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = va[i][1];
            b = va[i][0];
            #0.1;
            checks++;
            if (c_xor !== ex[i]) begin
                failures++;
                $display("FAIL lut_xor a=%b b=%b: got %b expected %b", va[i][1], va[i][0], c_xor, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_sequence();
        test_clk_stopped();
        test_reset_comb_path();
        test_registered();
        test_lut_xor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
